// File: rtl/rc5_key_expand.sv
// RC5-8 key schedule: byte-wide key load, then P/Q init and 3*max(T,c) mixing passes into S[0..T-1].
// done follows start by T+2N edges; start/key_wr are dropped while busy; S read port has 1-cycle latency.
module rc5_key_expand #(
  parameter int ROUNDS    = 5,
  parameter int KEY_BYTES = 4,
  localparam int T        = 2 * ROUNDS + 2,
  localparam int KAW      = $clog2((KEY_BYTES > 2) ? KEY_BYTES : 2),
  localparam int SAW      = $clog2(T)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           key_wr,
  input  logic [KAW-1:0] key_addr,
  input  logic [7:0]     key_data,
  input  logic           start,
  output logic           busy,
  output logic           done,
  input  logic [SAW-1:0] s_addr,
  output logic [7:0]     s_data
);

  localparam int N  = 3 * ((T > KEY_BYTES) ? T : KEY_BYTES);
  localparam int KW = $clog2(N + 1);
  localparam logic [7:0] P8 = 8'hB7;
  localparam logic [7:0] Q8 = 8'h9F;

  typedef enum logic [2:0] {IDLE, INIT, MIX_A, MIX_B, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]     k_mem [KEY_BYTES];
  logic [7:0]     l_mem [KEY_BYTES];
  logic [7:0]     s_mem [T];
  logic [7:0]     a_reg, b_reg;
  logic [SAW-1:0] i_cnt;
  logic [KAW-1:0] j_cnt;
  logic [KW-1:0]  k_cnt;

  logic       i_last, j_last, k_last;
  logic [7:0] ab_sum, mix_a_val, mix_b_val, init_val;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  assign i_last    = (i_cnt == SAW'(T - 1));
  assign j_last    = (j_cnt == KAW'(KEY_BYTES - 1));
  assign k_last    = (k_cnt == KW'(N - 1));
  assign ab_sum    = a_reg + b_reg;
  assign mix_a_val = rotl8(s_mem[i_cnt] + ab_sum, 3'd3);
  // In MIX_B a_reg already holds the A produced in the preceding MIX_A cycle.
  assign mix_b_val = rotl8(l_mem[j_cnt] + ab_sum, ab_sum[2:0]);
  assign init_val  = (i_cnt == '0) ? P8 : s_mem[i_cnt - 1'b1] + Q8;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = INIT;
      end
      INIT: begin
        busy = 1'b1;
        if (i_last) state_nxt = MIX_A;
      end
      MIX_A: begin
        busy      = 1'b1;
        state_nxt = MIX_B;
      end
      MIX_B: begin
        busy      = 1'b1;
        state_nxt = k_last ? DONE : MIX_A;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = INIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < KEY_BYTES; n++) begin
        k_mem[n] <= '0;
        l_mem[n] <= '0;
      end
      for (int n = 0; n < T; n++) s_mem[n] <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      i_cnt  <= '0;
      j_cnt  <= '0;
      k_cnt  <= '0;
      s_data <= '0;
    end else begin
      s_data <= (int'(s_addr) < T) ? s_mem[s_addr] : 8'h00;
      case (state)
        IDLE, DONE: begin
          if (key_wr && (int'(key_addr) < KEY_BYTES)) k_mem[key_addr] <= key_data;
          if (start) begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
            a_reg <= '0;
            b_reg <= '0;
            for (int n = 0; n < KEY_BYTES; n++) l_mem[n] <= k_mem[n];
          end
        end
        INIT: begin
          s_mem[i_cnt] <= init_val;
          if (i_last) begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        MIX_A: begin
          a_reg        <= mix_a_val;
          s_mem[i_cnt] <= mix_a_val;
        end
        MIX_B: begin
          b_reg        <= mix_b_val;
          l_mem[j_cnt] <= mix_b_val;
          i_cnt        <= i_last ? '0 : i_cnt + 1'b1;
          j_cnt        <= j_last ? '0 : j_cnt + 1'b1;
          k_cnt        <= k_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed bench for rc5_key_expand: a T=2/c=1 instance with hand-derived S values and a default
// T=12/c=4 instance compared against a sequential RC5-8 reference model.
module tb_rc5_key_expand;

  typedef logic [7:0] s_tab_t [12];
  typedef logic [7:0] key_t [4];
  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  logic       clock = 1'b0;
  logic       reset;

  logic       start0, key_wr0, busy0, done0;
  logic [0:0] key_addr0, s_addr0;
  logic [7:0] key_data0, s_data0;

  logic       start1, key_wr1, busy1, done1;
  logic [1:0] key_addr1;
  logic [3:0] s_addr1;
  logic [7:0] key_data1, s_data1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rc5_key_expand #(.ROUNDS(0), .KEY_BYTES(1)) u_small (
    .clock(clock), .reset(reset), .key_wr(key_wr0), .key_addr(key_addr0), .key_data(key_data0),
    .start(start0), .busy(busy0), .done(done0), .s_addr(s_addr0), .s_data(s_data0)
  );

  rc5_key_expand u_dut (
    .clock(clock), .reset(reset), .key_wr(key_wr1), .key_addr(key_addr1), .key_data(key_data1),
    .start(start1), .busy(busy1), .done(done1), .s_addr(s_addr1), .s_data(s_data1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  task automatic rc5_ref(input key_t key, output s_tab_t s);
    key_t       l;
    logic [7:0] a, b, sum;
    int         i, j;
    l = key; a = 8'h00; b = 8'h00; i = 0; j = 0;
    s[0] = 8'hB7;
    for (int h = 1; h < 12; h++) s[h] = s[h-1] + 8'h9F;
    for (int k = 0; k < 3 * 12; k++) begin
      a    = rotl(s[i] + a + b, 3);
      s[i] = a;
      sum  = a + b;
      b    = rotl(l[j] + sum, sum % 8);
      l[j] = b;
      i    = (i + 1) % 12;
      j    = (j + 1) % 4;
    end
  endtask

  task automatic wr_key1(input logic [1:0] a, input logic [7:0] d);
    key_wr1 = 1'b1; key_addr1 = a; key_data1 = d;
    @(posedge clock); #1;
    key_wr1 = 1'b0;
  endtask

  task automatic load_key1(input key_t k);
    for (int n = 0; n < 4; n++) wr_key1(2'(n), k[n]);
  endtask

  // dist_kind 1: re-pulse start and write K[0]=FF at cycle dist_at; 2: assert reset after edge dist_at.
  task automatic run1(input int dist_at, input int dist_kind, output int lat, output int bcyc);
    lat = 0; bcyc = 0;
    s_addr1 = 4'd0;
    start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    chk("done low after start", done1, 1'b0);
    while (!done1 && lat < 300) begin
      if (busy1) bcyc++;
      if (dist_kind == 1 && lat == dist_at) begin
        start1 = 1'b1; key_wr1 = 1'b1; key_addr1 = 2'd0; key_data1 = 8'hFF;
      end
      @(posedge clock); #1;
      lat++;
      start1 = 1'b0; key_wr1 = 1'b0;
      if (dist_kind == 2 && lat == dist_at) begin
        reset = 1'b1;
        #1;
        chk("busy after mid-run reset", busy1, 1'b0);
        chk("done after mid-run reset", done1, 1'b0);
        chk("s_data after mid-run reset", s_data1, 8'h00);
        return;
      end
    end
  endtask

  task automatic check_s1(input s_tab_t r, input string tag);
    rd_vec_t v [16];
    for (int n = 0; n < 16; n++) begin
      v[n].addr = 4'(n);
      v[n].exp  = (n < 12) ? r[n] : 8'h00;
    end
    for (int n = 0; n < 16; n++) begin
      s_addr1 = v[n].addr;
      @(posedge clock); #1;
      chk($sformatf("%s S[%0d]", tag, n), s_data1, v[n].exp);
    end
  endtask

  initial begin
    rd_vec_t small_vecs [2];
    s_tab_t  exp_tab;
    key_t    cur_key;
    int      lat, bcyc;

    small_vecs[0] = '{addr: 4'd0, exp: 8'hC6};
    small_vecs[1] = '{addr: 4'd1, exp: 8'h34};

    reset = 1'b1;
    start0 = 0; key_wr0 = 0; key_addr0 = '0; key_data0 = '0; s_addr0 = '0;
    start1 = 0; key_wr1 = 0; key_addr1 = '0; key_data1 = '0; s_addr1 = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset busy0", busy0, 1'b0);
    chk("reset done0", done0, 1'b0);
    chk("reset s_data0", s_data0, 8'h00);
    chk("reset busy1", busy1, 1'b0);
    chk("reset done1", done1, 1'b0);
    chk("reset s_data1", s_data1, 8'h00);
    reset = 1'b0;
    @(posedge clock); #1;

    // T=2, c=1 instance, K[0]=0x00
    key_wr0 = 1'b1; key_addr0 = 1'b0; key_data0 = 8'h00;
    @(posedge clock); #1;
    key_wr0 = 1'b0;
    lat = 0; bcyc = 0;
    start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    while (!done0 && lat < 100) begin
      if (busy0) bcyc++;
      @(posedge clock); #1;
      lat++;
    end
    chk("small latency", lat, 14);
    chk("small busy cycles", bcyc, 14);
    for (int n = 0; n < 2; n++) begin
      s_addr0 = small_vecs[n].addr[0];
      @(posedge clock); #1;
      chk($sformatf("small S[%0d]", n), s_data0, small_vecs[n].exp);
    end

    // default instance, key 01 02 03 04
    cur_key = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_key1(cur_key);
    rc5_ref(cur_key, exp_tab);
    run1(-1, 0, lat, bcyc);
    chk("run1 latency", lat, 84);
    chk("run1 busy cycles", bcyc, 84);
    check_s1(exp_tab, "run1");

    // restart from DONE with unchanged key
    run1(-1, 0, lat, bcyc);
    chk("rerun latency", lat, 84);
    check_s1(exp_tab, "rerun");

    // start and key_wr while busy must be ignored
    run1(20, 1, lat, bcyc);
    chk("busy-ignore latency", lat, 84);
    check_s1(exp_tab, "busy-ignore");
    run1(-1, 0, lat, bcyc);
    chk("key-kept latency", lat, 84);
    check_s1(exp_tab, "key-kept");

    // a different key pattern
    cur_key = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
    load_key1(cur_key);
    rc5_ref(cur_key, exp_tab);
    run1(-1, 0, lat, bcyc);
    chk("key2 latency", lat, 84);
    check_s1(exp_tab, "key2");

    // reset mid-run, then reload and recompute
    run1(40, 2, lat, bcyc);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post-reset done1", done1, 1'b0);
    cur_key = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_key1(cur_key);
    rc5_ref(cur_key, exp_tab);
    run1(-1, 0, lat, bcyc);
    chk("post-reset latency", lat, 84);
    chk("post-reset busy cycles", bcyc, 84);
    check_s1(exp_tab, "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
